game_flow_ctrl: RTL
===================

Name: game_flow_ctrl

Overview:
- Top-level game-flow sequencer for the multi-player kitchen game: welcome/team-name entry, pre-game countdown, play, pause and finish screens.
- Generalises the single-player menu controller:
  - parametrised team-name length, character range and player count;
  - edge-detected, OR-merged inputs from all players;
  - a timed finish screen that returns to the welcome screen.
- Sits between the per-player input synchronisers and the time_remaining / orders_and_points / renderer blocks. It runs on the system clock and advances only on frame ticks.

Parameters:
- NAME_LEN, 3: number of team-name characters (1..8).
- CHAR_MIN, 8'h41: lowest legal character ('A').
- CHAR_MAX, 8'h5A: highest legal character ('Z').
- NUM_PLAYERS, 4: number of button channels (1..4).
- START_FRAMES, 300: frames spent in START before PLAY.
- RESULT_FRAMES, 600: minimum frames spent in FINISH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-clk pulse per video frame; all state updates happen only on clk edges where frame_tick=1.
- btn_left, btn_right, btn_up, btn_down, btn_chop, btn_carry  in  NUM_PLAYERS each  synchronised button levels, one bit per player.
- time_expired  in  1  round timer reached zero.
- game_state  out  3  0 WELCOME, 1 START, 2 PLAY, 3 PAUSE, 4 FINISH.
- team_name  out  NAME_LEN*8  packed characters; byte NAME_LEN-1 is the leftmost character (cursor 0).
- cursor  out  3  character currently being edited.
- timer_go  out  1  round timer runs.
- restart_timer  out  1  round timer reload.
- frames_left  out  16  remaining frames in the START/FINISH countdown; 0 in other states.

Behaviour:
- **Reset:** on reset, at any clk edge regardless of frame_tick:
  - game_state=WELCOME, every character=CHAR_MIN, cursor=0, frames_left=0;
  - previous-button registers cleared to 0;
  - any state and its counters are abandoned mid-operation.
- **Input edges:**
  - On each tick, press_X = OR over players of (btn_X & ~prev_X); then prev_X <= btn_X.
  - hold_X = OR over players of btn_X, at the current tick.
  - Several players pressing the same button on the same tick count as one press.
  - Only one press action is taken per tick, priority chop > up > down > right > left.
- **WELCOME:**
  - press_chop: go to START, frames_left=START_FRAMES.
  - press_up: decrement the character at cursor; CHAR_MIN wraps to CHAR_MAX.
  - press_down: increment; CHAR_MAX wraps to CHAR_MIN.
  - press_right: cursor+1, saturating at NAME_LEN-1.
  - press_left: cursor-1, saturating at 0.
  - Characters not under the cursor never change.
- **START:**
  - frames_left decrements by 1 each tick.
  - On the tick where frames_left==1: frames_left=0 and go to PLAY on that same tick, i.e. exactly START_FRAMES ticks after entry.
  - Buttons are ignored; prev registers still update.
- **PLAY:**
  - time_expired=1 on a tick: go to FINISH with frames_left=RESULT_FRAMES.
  - Otherwise, hold_chop & hold_carry from the same player: go to PAUSE.
  - FINISH beats PAUSE when both occur on the same tick.
- **PAUSE:**
  - press_chop & ~hold_carry: go to PLAY.
  - time_expired is ignored while paused.
- **FINISH:**
  - frames_left decrements to 0 and then holds.
  - When frames_left==0 and press_chop: go to WELCOME, cursor=0. team_name is retained, not cleared.
  - A chop press before the countdown reaches 0 is discarded.
- **Combinational outputs:**
  - timer_go=1 iff game_state==PLAY.
  - restart_timer=1 iff game_state is WELCOME or START.
- **Encoding:** illegal game_state encodings (5-7) go to WELCOME on the next tick.
- **Latency:** a state change is visible on the clk edge that consumes the tick. No change occurs on non-tick cycles.

Test Plan:
- **Reset / character wrap:**
  - Stimulus: reset; 1 tick of btn_up[0]; release; 1 tick of btn_down[0].
  - Required: team_name = 0x5A4141 after the up press, then 0x414141 after the down press.
- **Cursor and multi-player merge:**
  - Stimulus: btn_right from players 0 and 2 on the same tick; then press_down; then 5 separate press_left.
  - Required: cursor=1 (not 2); team_name = 0x414241; cursor ends at 0 (saturated).
- **Start countdown:**
  - Stimulus: START_FRAMES=4; press chop.
  - Required: game_state=1 with frames_left 4,3,2,1 on successive ticks; game_state=2 with timer_go=1 on the 4th tick after entry.
- **Pause/resume:**
  - Stimulus: in PLAY, player 1 holds chop+carry; then player 1 presses chop with carry released.
  - Required: game_state=3 with timer_go=0; then game_state=2.
  - Stimulus: chop from player 0 with carry from player 3 on the same tick.
  - Required: no pause.
- **Finish priority and hold:**
  - Stimulus: time_expired together with chop+carry; RESULT_FRAMES=3; chop pressed at frames_left=2, then again after frames_left reaches 0.
  - Required: game_state=4 (not 3); the early chop is ignored; the late chop gives WELCOME with team_name unchanged.
- **Mid-operation reset:**
  - Stimulus: assert reset in PAUSE with frame_tick=0.
  - Required: next clk gives game_state=0, frames_left=0, restart_timer=1.

Source files
------------

// File: rtl/game_flow_ctrl_if.sv
// Interface bundling the frame tick, merged player buttons, round-timer
// status and the game-flow outputs that feed the timer and renderer blocks.
interface game_flow_ctrl_if #(
    parameter int NAME_LEN    = 3,
    parameter int NUM_PLAYERS = 4
) ();
    logic                   frame_tick;
    logic [NUM_PLAYERS-1:0] btn_left;
    logic [NUM_PLAYERS-1:0] btn_right;
    logic [NUM_PLAYERS-1:0] btn_up;
    logic [NUM_PLAYERS-1:0] btn_down;
    logic [NUM_PLAYERS-1:0] btn_chop;
    logic [NUM_PLAYERS-1:0] btn_carry;
    logic                   time_expired;
    logic [2:0]             game_state;
    logic [NAME_LEN*8-1:0]  team_name;
    logic [2:0]             cursor;
    logic                   timer_go;
    logic                   restart_timer;
    logic [15:0]            frames_left;

    // Stimulus side: input synchronisers and round timer.
    modport master (
        output frame_tick, btn_left, btn_right, btn_up, btn_down,
               btn_chop, btn_carry, time_expired,
        input  game_state, team_name, cursor, timer_go, restart_timer,
               frames_left
    );

    // Controller side.
    modport slave (
        input  frame_tick, btn_left, btn_right, btn_up, btn_down,
               btn_chop, btn_carry, time_expired,
        output game_state, team_name, cursor, timer_go, restart_timer,
               frames_left
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: team-name entry, pre-game countdown, play, pause and
// a timed finish screen. All state advances only on frame ticks.
module game_flow_ctrl #(
    parameter int          NAME_LEN      = 3,
    parameter logic [7:0]  CHAR_MIN      = 8'h41,
    parameter logic [7:0]  CHAR_MAX      = 8'h5A,
    parameter int          NUM_PLAYERS   = 4,
    parameter int          START_FRAMES  = 300,
    parameter int          RESULT_FRAMES = 600
) (
    input  logic            clk,
    input  logic            reset,
    game_flow_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_WELCOME = 3'd0,
        ST_START   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    localparam logic [2:0]  CUR_MAX     = 3'(NAME_LEN - 1);
    localparam logic [15:0] START_LOAD  = 16'(START_FRAMES);
    localparam logic [15:0] RESULT_LOAD = 16'(RESULT_FRAMES);

    state_t                 state_r, state_next_s;
    logic [NAME_LEN*8-1:0]  name_r, name_next_s;
    logic [2:0]             cursor_r, cursor_next_s;
    logic [15:0]            frames_r, frames_next_s;
    logic                   timer_go_r, restart_r;

    logic [NUM_PLAYERS-1:0] prev_left_r, prev_right_r, prev_up_r;
    logic [NUM_PLAYERS-1:0] prev_down_r, prev_chop_r, prev_carry_r;

    logic press_left_s, press_right_s, press_up_s, press_down_s, press_chop_s;
    logic hold_carry_s, pause_req_s;
    logic edit_s, edit_up_s;

    // Rising edges merged across players; simultaneous presses count once.
    assign press_left_s  = |(bus.btn_left  & ~prev_left_r);
    assign press_right_s = |(bus.btn_right & ~prev_right_r);
    assign press_up_s    = |(bus.btn_up    & ~prev_up_r);
    assign press_down_s  = |(bus.btn_down  & ~prev_down_r);
    assign press_chop_s  = |(bus.btn_chop  & ~prev_chop_r);
    assign hold_carry_s  = |bus.btn_carry;
    // Pause needs chop and carry held by the same player.
    assign pause_req_s   = |(bus.btn_chop & bus.btn_carry);

    // Step one character up or down the legal range with wrap-around.
    function automatic logic [7:0] char_step(input logic [7:0] ch,
                                             input logic       dec);
        logic [7:0] res;
        if (dec) begin
            if (ch == CHAR_MIN) res = CHAR_MAX;
            else                res = ch - 8'd1;
        end else begin
            if (ch == CHAR_MAX) res = CHAR_MIN;
            else                res = ch + 8'd1;
        end
        return res;
    endfunction

    // Next-state, counter, cursor and name-edit decode for one frame tick.
    always_comb begin
        state_next_s  = state_r;
        name_next_s   = name_r;
        cursor_next_s = cursor_r;
        frames_next_s = frames_r;
        edit_s        = 1'b0;
        edit_up_s     = 1'b0;

        case (state_r)
            ST_WELCOME: begin
                if (press_chop_s) begin
                    state_next_s  = ST_START;
                    frames_next_s = START_LOAD;
                end else if (press_up_s) begin
                    edit_s    = 1'b1;
                    edit_up_s = 1'b1;
                end else if (press_down_s) begin
                    edit_s    = 1'b1;
                end else if (press_right_s) begin
                    if (cursor_r < CUR_MAX) cursor_next_s = cursor_r + 3'd1;
                    else                    cursor_next_s = cursor_r;
                end else if (press_left_s) begin
                    if (cursor_r != 3'd0) cursor_next_s = cursor_r - 3'd1;
                    else                  cursor_next_s = cursor_r;
                end else begin
                    state_next_s = ST_WELCOME;
                end
            end
            ST_START: begin
                if (frames_r <= 16'd1) begin
                    frames_next_s = 16'd0;
                    state_next_s  = ST_PLAY;
                end else begin
                    frames_next_s = frames_r - 16'd1;
                end
            end
            ST_PLAY: begin
                if (bus.time_expired) begin
                    state_next_s  = ST_FINISH;
                    frames_next_s = RESULT_LOAD;
                end else if (pause_req_s) begin
                    state_next_s = ST_PAUSE;
                end else begin
                    state_next_s = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                if (press_chop_s && !hold_carry_s) state_next_s = ST_PLAY;
                else                               state_next_s = ST_PAUSE;
            end
            ST_FINISH: begin
                if (frames_r != 16'd0) begin
                    // Chop presses during the countdown are discarded.
                    frames_next_s = frames_r - 16'd1;
                end else if (press_chop_s) begin
                    state_next_s  = ST_WELCOME;
                    cursor_next_s = 3'd0;
                end else begin
                    state_next_s = ST_FINISH;
                end
            end
            default: begin
                state_next_s  = ST_WELCOME;
                frames_next_s = 16'd0;
            end
        endcase

        // Only the character under the cursor is ever modified.
        for (int i = 0; i < NAME_LEN; i++) begin
            if (edit_s && (cursor_r == 3'(i))) begin
                name_next_s[(NAME_LEN-1-i)*8 +: 8] =
                    char_step(name_r[(NAME_LEN-1-i)*8 +: 8], edit_up_s);
            end else begin
                name_next_s[(NAME_LEN-1-i)*8 +: 8] = name_r[(NAME_LEN-1-i)*8 +: 8];
            end
        end
    end

    // State, counters, name and button history; advance only on frame ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_WELCOME;
            name_r       <= {NAME_LEN{CHAR_MIN}};
            cursor_r     <= 3'd0;
            frames_r     <= 16'd0;
            timer_go_r   <= 1'b0;
            restart_r    <= 1'b1;
            prev_left_r  <= '0;
            prev_right_r <= '0;
            prev_up_r    <= '0;
            prev_down_r  <= '0;
            prev_chop_r  <= '0;
            prev_carry_r <= '0;
        end else if (bus.frame_tick) begin
            state_r      <= state_next_s;
            name_r       <= name_next_s;
            cursor_r     <= cursor_next_s;
            frames_r     <= frames_next_s;
            // Registered from next state so they track game_state exactly.
            timer_go_r   <= (state_next_s == ST_PLAY);
            restart_r    <= (state_next_s == ST_WELCOME) ||
                            (state_next_s == ST_START);
            prev_left_r  <= bus.btn_left;
            prev_right_r <= bus.btn_right;
            prev_up_r    <= bus.btn_up;
            prev_down_r  <= bus.btn_down;
            prev_chop_r  <= bus.btn_chop;
            prev_carry_r <= bus.btn_carry;
        end
    end

    assign bus.game_state    = state_r;
    assign bus.team_name     = name_r;
    assign bus.cursor        = cursor_r;
    assign bus.frames_left   = frames_r;
    assign bus.timer_go      = timer_go_r;
    assign bus.restart_timer = restart_r;

endmodule
